// File: rtl/seq_det_ctrl.sv
// Word-to-bit sequencer for a serial pattern detector: serializes NUM_WORDS words MSB-first,
// counts the detector's match pulses and signals job completion.
module seq_det_ctrl #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned NWORD_W = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NWORD_W-1:0] num_words_i,
  input  logic               abort_i,
  input  logic [WORD_W-1:0]  in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               det_rst_o,
  output logic               det_en_o,
  output logic               det_a_o,
  input  logic               det_z_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   match_cnt_o
);

  localparam int unsigned BitW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StShift,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [NWORD_W-1:0] words_left_q, words_left_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               en_q, en_d;
  logic               abort_rst_q, abort_rst_d;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    match_cnt_d  = match_cnt_q;
    en_d         = (state_q == StShift);
    abort_rst_d  = abort_i && (state_q != StIdle);

    // det_z refers to the bit shifted one cycle earlier; an abort freezes the count
    if (en_q && det_z_i && (state_q != StIdle) && !abort_i &&
        (match_cnt_q != {CNT_W{1'b1}})) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          words_left_d = num_words_i;
          state_d      = StClear;
        end
      end
      StClear: begin
        match_cnt_d = '0;
        state_d     = (words_left_q == '0) ? StDone : StLoad;
      end
      StLoad: begin
        if (in_valid_i) begin
          sr_d      = in_data_i;
          bit_cnt_d = BitW'(WORD_W - 1);
          state_d   = StShift;
        end
      end
      StShift: begin
        sr_d      = sr_q << 1;
        bit_cnt_d = bit_cnt_q - BitW'(1);
        if (bit_cnt_q == '0) begin
          words_left_d = words_left_q - NWORD_W'(1);
          state_d      = (words_left_q == NWORD_W'(1)) ? StDrain : StLoad;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      words_left_q <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      match_cnt_q  <= '0;
      en_q         <= 1'b0;
      abort_rst_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      match_cnt_q  <= match_cnt_d;
      en_q         <= en_d;
      abort_rst_q  <= abort_rst_d;
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StLoad);
    det_en_o    = (state_q == StShift);
    det_a_o     = (state_q == StShift) && sr_q[WORD_W-1];
    det_rst_o   = (state_q == StClear) || abort_rst_q;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StDone);
    match_cnt_o = match_cnt_q;
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl with a behavioural overlapping '10010' detector attached.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, in_valid;
  logic [7:0] num_words, in_data;
  logic       in_ready, det_rst, det_en, det_a, det_z, busy, done;
  logic [7:0] match_cnt;
  logic       in_ready2, det_rst2, det_en2, det_a2, busy2, done2;
  logic [1:0] match_cnt2;

  seq_det_ctrl #(.WORD_W(8), .NWORD_W(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_words_i(num_words), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .det_rst_o(det_rst),
    .det_en_o(det_en), .det_a_o(det_a), .det_z_i(det_z), .busy_o(busy), .done_o(done),
    .match_cnt_o(match_cnt)
  );

  // Narrow-counter instance for saturation; shares the same detector stream
  seq_det_ctrl #(.WORD_W(8), .NWORD_W(8), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_words_i(num_words), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready2), .det_rst_o(det_rst2),
    .det_en_o(det_en2), .det_a_o(det_a2), .det_z_i(det_z), .busy_o(busy2), .done_o(done2),
    .match_cnt_o(match_cnt2)
  );

  logic [4:0] hist;
  always @(posedge clk) begin
    if (rst || det_rst) begin
      hist  <= 5'b0;
      det_z <= 1'b0;
    end else if (det_en) begin
      hist  <= {hist[3:0], det_a};
      det_z <= ({hist[3:0], det_a} == 5'b10010);
    end else begin
      det_z <= 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         nw;
    logic [7:0] w[4];
    int         stall;
    int         poke;
    int         cnt;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic set_vec(input int i, input int nw, input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3, input int stall,
                         input int poke, input int cnt, input int lat);
    vecs[i].nw    = nw;
    vecs[i].w[0]  = w0;
    vecs[i].w[1]  = w1;
    vecs[i].w[2]  = w2;
    vecs[i].w[3]  = w3;
    vecs[i].stall = stall;
    vecs[i].poke  = poke;
    vecs[i].cnt   = cnt;
    vecs[i].lat   = lat;
  endtask

  task automatic run_job(input int i);
    int cyc, lat, en_n, rdy_n, viol, idx, stall_left, exp2, got, got2;
    lat = -1; en_n = 0; rdy_n = 0; viol = 0; idx = 0; cyc = 0;
    stall_left = vecs[i].stall;
    exp2 = (vecs[i].cnt > 3) ? 3 : vecs[i].cnt;
    got = 0; got2 = 0;
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'(vecs[i].nw);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == vecs[i].poke);
      if (start) num_words = 8'd0;
      if (det_en) en_n++;
      if (in_ready) rdy_n++;
      if (in_ready && det_en) viol++;
      if (!det_en && det_a) viol++;
      if ({in_ready2, det_rst2, det_en2, det_a2, busy2, done2} !=
          {in_ready, det_rst, det_en, det_a, busy, done}) viol++;
      if (done) begin
        lat  = cyc;
        got  = int'(match_cnt);
        got2 = int'(match_cnt2);
        break;
      end
      if (in_ready && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else if (in_ready && idx < 4) begin
        in_valid = 1'b1;
        in_data  = vecs[i].w[idx];
        idx++;
      end else begin
        in_valid = 1'b0;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
    chk($sformatf("v%0d match_cnt", i), got, vecs[i].cnt);
    chk($sformatf("v%0d match_cnt_w2", i), got2, exp2);
    chk($sformatf("v%0d det_en_cycles", i), en_n, 8 * vecs[i].nw);
    chk($sformatf("v%0d in_ready_cycles", i), rdy_n, vecs[i].nw + vecs[i].stall);
    chk($sformatf("v%0d protocol_viol", i), viol, 0);
    @(negedge clk);
    chk($sformatf("v%0d idle_after", i), {done, busy}, 0);
    chk($sformatf("v%0d cnt_held", i), int'(match_cnt), vecs[i].cnt);
  endtask

  // Two 0x92 words; kill the job on the 3rd SHIFT cycle of the second word
  task automatic part_job(input bit use_rst);
    int en_n, hit, done_n, rstp_n;
    en_n = 0; hit = 0; done_n = 0; rstp_n = 0;
    @(negedge clk);
    start     = 1'b1;
    num_words = 8'd2;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (det_en) en_n++;
      if (det_en && en_n == 11) begin
        hit = 1;
        break;
      end
      in_valid = in_ready;
      in_data  = 8'h92;
    end
    in_valid = 1'b0;
    chk(use_rst ? "rst_point_reached" : "abort_point_reached", hit, 1);
    chk(use_rst ? "cnt_before_rst" : "cnt_before_abort", int'(match_cnt), 2);
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    if (use_rst) begin
      chk("rst_mid_shift_outputs",
          int'({in_ready, det_rst, det_en, det_a, busy, done, match_cnt}), 0);
      chk("rst_mid_shift_cnt_w2", int'(match_cnt2), 0);
    end else begin
      chk("abort_busy", int'(busy), 0);
      chk("abort_det_rst", int'(det_rst), 1);
      chk("abort_done", int'(done), 0);
      chk("abort_det_en", int'(det_en), 0);
      chk("abort_cnt", int'(match_cnt), 2);
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) done_n++;
        if (det_rst) rstp_n++;
      end
      chk("abort_no_done", done_n, 0);
      chk("abort_det_rst_pulse", rstp_n, 0);
      chk("abort_cnt_frozen", int'(match_cnt), 2);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    num_words = 8'd0; in_data = 8'd0;
    set_vec(0, 1, 8'h92, 8'h00, 8'h00, 8'h00, 0, -1, 2, 12);
    set_vec(1, 2, 8'h01, 8'h20, 8'h00, 8'h00, 0, -1, 1, 21);
    set_vec(2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 0, 12);
    set_vec(3, 1, 8'h92, 8'h00, 8'h00, 8'h00, 5, -1, 2, 17);
    set_vec(4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, -1, 0, 2);
    set_vec(5, 4, 8'h92, 8'h92, 8'h92, 8'h92, 0, -1, 8, 39);
    set_vec(6, 1, 8'h92, 8'h00, 8'h00, 8'h00, 0, 5, 2, 12);

    repeat (2) @(negedge clk);
    chk("reset_ctrl_outputs", int'({in_ready, det_rst, det_en, det_a, busy, done}), 0);
    chk("reset_match_cnt", int'(match_cnt), 0);
    chk("reset_match_cnt_w2", int'(match_cnt2), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_job(i);

    part_job(1'b0);
    part_job(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
